// File: rtl/pipe_memwb_reg.sv
// pipe_memwb_reg -- MEM/WB pipeline register of the 5-stage CPU.
//
// Captures the MEM-stage result on each clk edge and presents it to write-back
// and the forwarding unit. Load data is aligned and sign/zero-extended here,
// before the register, so WB sees a ready-to-write value one cycle after MEM.
// All outputs are registered; no input reaches an output combinationally.
//
// Optional feature macro: PIPE_MEMWB_ALIGN_CHK_EN
//   defined   : misaligned loads set w_misalign and suppress w_wreg
//   undefined : no check, w_misalign tied 0
//
// Ports
//   clk, rst           pipeline clock, synchronous active-high reset
//   stall, flush       hold outputs / insert bubble (rst > flush > stall)
//   m_valid, m_wreg    MEM-stage valid and register-write request
//   m_m2reg            load: result comes from m_memout
//   m_w, m_h, m_b      access size (priority w > h > b, none = word)
//   m_sext             sign-extend sub-word loads
//   m_rn               destination register index
//   m_alu              ALU result / memory address
//   m_memout           raw memory read word
//   w_valid, w_wreg    WB valid and qualified register-file write enable
//   w_rn, w_data       WB destination and write data
//   w_misalign         misaligned-load flag
module pipe_memwb_reg #(
  parameter int RN_W   = 5,
  parameter int DATA_W = 32   // only 32 supported
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              m_valid,
  input  logic              m_wreg,
  input  logic              m_m2reg,
  input  logic              m_w,
  input  logic              m_h,
  input  logic              m_b,
  input  logic              m_sext,
  input  logic [RN_W-1:0]   m_rn,
  input  logic [DATA_W-1:0] m_alu,
  input  logic [DATA_W-1:0] m_memout,
  output logic              w_valid,
  output logic              w_wreg,
  output logic [RN_W-1:0]   w_rn,
  output logic [DATA_W-1:0] w_data,
  output logic              w_misalign
);

  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld;
  logic [DATA_W-1:0] sel;
  logic              is_half;
  logic              is_byte;
  logic              misalign;

  // Size decode: word wins, and a load with no size bit set is a word.
  assign is_half = !m_w && m_h;
  assign is_byte = !m_w && !m_h && m_b;

  // Little-endian lane select.
  always_comb begin
    ld_byte = 8'h00;
    case (m_alu[1:0])
      2'd0: ld_byte = m_memout[7:0];
      2'd1: ld_byte = m_memout[15:8];
      2'd2: ld_byte = m_memout[23:16];
      2'd3: ld_byte = m_memout[31:24];
      default: ld_byte = 8'h00;
    endcase
  end

  assign ld_half = m_alu[1] ? m_memout[31:16] : m_memout[15:0];

  always_comb begin
    ld = m_memout;
    if (is_half)
      ld = {{16{m_sext & ld_half[15]}}, ld_half};
    else if (is_byte)
      ld = {{24{m_sext & ld_byte[7]}}, ld_byte};
  end

  assign sel = m_m2reg ? ld : m_alu;

`ifdef PIPE_MEMWB_ALIGN_CHK_EN
  // Only valid loads can be misaligned; stores and ALU ops are never flagged.
  always_comb begin
    misalign = 1'b0;
    if (m_valid && m_m2reg) begin
      if (is_half)
        misalign = m_alu[0];
      else if (!is_byte)
        misalign = |m_alu[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush)
      w_misalign <= 1'b0;
    else if (!stall)
      w_misalign <= misalign;
  end
`else
  assign misalign   = 1'b0;
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      w_valid <= 1'b0;
      w_wreg  <= 1'b0;
      w_rn    <= '0;
      w_data  <= '0;
    end else if (!stall) begin
      w_valid <= m_valid;
      w_wreg  <= m_wreg && m_valid && !misalign;
      w_rn    <= m_rn;
      w_data  <= sel;
    end
  end

endmodule

// File: tb/tb_pipe_memwb_reg.sv
module tb_pipe_memwb_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        m_valid, m_wreg, m_m2reg, m_w, m_h, m_b, m_sext;
  logic [4:0]  m_rn;
  logic [31:0] m_alu, m_memout;
  logic        w_valid, w_wreg, w_misalign;
  logic [4:0]  w_rn;
  logic [31:0] w_data;

  always #5 clk = ~clk;

  pipe_memwb_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_wreg(m_wreg), .m_m2reg(m_m2reg),
    .m_w(m_w), .m_h(m_h), .m_b(m_b), .m_sext(m_sext),
    .m_rn(m_rn), .m_alu(m_alu), .m_memout(m_memout),
    .w_valid(w_valid), .w_wreg(w_wreg), .w_rn(w_rn),
    .w_data(w_data), .w_misalign(w_misalign)
  );

`ifdef PIPE_MEMWB_ALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct packed {
    logic        v;
    logic        wr;
    logic [4:0]  rn;
    logic [31:0] d;
    logic        mis;
  } exp_t;

  typedef struct packed {
    logic        rst, stall, flush, valid, wreg, m2reg, w, h, b, sext;
    logic [4:0]  rn;
    logic [31:0] alu, memout;
  } in_t;

  typedef struct {
    string name;
    in_t   in;
    exp_t  ex;
  } vec_t;

  exp_t q[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  vec_t tbl[$];

  localparam logic [31:0] MEM = 32'h8899_AA7F;
  localparam exp_t ZERO = '{v:1'b0, wr:1'b0, rn:5'd0, d:32'h0, mis:1'b0};

  function automatic in_t mk_in(logic vl, logic wr, logic m2, logic w, logic h,
                                logic b, logic sx, logic [4:0] rn, logic [31:0] alu);
    in_t i;
    i = '{rst:1'b0, stall:1'b0, flush:1'b0, valid:vl, wreg:wr, m2reg:m2, w:w, h:h,
          b:b, sext:sx, rn:rn, alu:alu, memout:MEM};
    return i;
  endfunction

  function automatic exp_t mk_ex(logic v, logic wr, logic [4:0] rn, logic [31:0] d, logic mis);
    exp_t e;
    e = '{v:v, wr:wr, rn:rn, d:d, mis:mis};
    return e;
  endfunction

  function automatic in_t rnd_in();
    in_t i;
    i = in_t'({$urandom, $urandom, $urandom});
    return i;
  endfunction

  task automatic drive(input in_t i);
    rst = i.rst; stall = i.stall; flush = i.flush;
    m_valid = i.valid; m_wreg = i.wreg; m_m2reg = i.m2reg;
    m_w = i.w; m_h = i.h; m_b = i.b; m_sext = i.sext;
    m_rn = i.rn; m_alu = i.alu; m_memout = i.memout;
  endtask

  // Drive on the falling edge, queue the expectation, and compare #1 after the
  // capturing edge.
  task automatic step(input string name, input in_t i, input exp_t e);
    exp_t got, want;
    @(negedge clk);
    drive(i);
    q.push_back(e);
    @(posedge clk);
    #1;
    want = q.pop_front();
    got  = '{v:w_valid, wr:w_wreg, rn:w_rn, d:w_data, mis:w_misalign};
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got v=%b wr=%b rn=%0d d=%h mis=%b, want v=%b wr=%b rn=%0d d=%h mis=%b",
                  name, got.v, got.wr, got.rn, got.d, got.mis,
                  want.v, want.wr, want.rn, want.d, want.mis);
  endtask

  initial begin
    in_t  ri;
    in_t  a_in;
    exp_t a_ex;

    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0));

    // Reset with random inputs, including random stall/flush.
    for (int k = 0; k < 2; k++) begin
      ri = rnd_in();
      ri.rst = 1'b1;
      step("reset", ri, ZERO);
    end

    tbl.push_back('{"alu_pass", mk_in(1,1,0,0,0,0,0,5'd5,32'h1234_5678), mk_ex(1,1,5'd5,32'h1234_5678,0)});
    tbl.push_back('{"lb_a0",    mk_in(1,1,1,0,0,1,1,5'd7,32'h0000_0100), mk_ex(1,1,5'd7,32'h0000_007F,0)});
    tbl.push_back('{"lb_a1",    mk_in(1,1,1,0,0,1,1,5'd7,32'h0000_0101), mk_ex(1,1,5'd7,32'hFFFF_FFAA,0)});
    tbl.push_back('{"lbu_a3",   mk_in(1,1,1,0,0,1,0,5'd7,32'h0000_0103), mk_ex(1,1,5'd7,32'h0000_0088,0)});
    tbl.push_back('{"lh_10",    mk_in(1,1,1,0,1,0,1,5'd8,32'h0000_0010), mk_ex(1,1,5'd8,32'hFFFF_AA7F,0)});
    tbl.push_back('{"lhu_12",   mk_in(1,1,1,0,1,0,0,5'd8,32'h0000_0012), mk_ex(1,1,5'd8,32'h0000_8899,0)});
    tbl.push_back('{"lw",       mk_in(1,1,1,1,0,0,1,5'd9,32'h0000_0010), mk_ex(1,1,5'd9,32'h8899_AA7F,0)});
    tbl.push_back('{"size_prio",mk_in(1,1,1,1,1,1,1,5'd9,32'h0000_0014), mk_ex(1,1,5'd9,32'h8899_AA7F,0)});
    tbl.push_back('{"no_size",  mk_in(1,1,1,0,0,0,1,5'd9,32'h0000_0018), mk_ex(1,1,5'd9,32'h8899_AA7F,0)});
    tbl.push_back('{"sext_alu", mk_in(1,1,0,0,0,1,1,5'd2,32'h8000_0081), mk_ex(1,1,5'd2,32'h8000_0081,0)});
    tbl.push_back('{"rn0_pass", mk_in(1,1,0,0,0,0,0,5'd0,32'h0000_00AA), mk_ex(1,1,5'd0,32'h0000_00AA,0)});
    tbl.push_back('{"inv_wreg", mk_in(0,1,0,0,0,0,0,5'd3,32'h0000_0055), mk_ex(0,0,5'd3,32'h0000_0055,0)});
    tbl.push_back('{"lh_mis",   mk_in(1,1,1,0,1,0,0,5'd4,32'h0000_0011), mk_ex(1,!CHK,5'd4,32'h0000_AA7F,CHK)});
    tbl.push_back('{"lw_ok",    mk_in(1,1,1,1,0,0,0,5'd4,32'h0000_0020), mk_ex(1,1,5'd4,32'h8899_AA7F,0)});
    tbl.push_back('{"lw_mis",   mk_in(1,1,1,1,0,0,0,5'd6,32'h0000_0022), mk_ex(1,!CHK,5'd6,32'h8899_AA7F,CHK)});
    tbl.push_back('{"lb_odd",   mk_in(1,1,1,0,0,1,0,5'd6,32'h0000_0023), mk_ex(1,1,5'd6,32'h0000_0088,0)});
    tbl.push_back('{"inv_mis",  mk_in(0,1,1,0,1,0,0,5'd6,32'h0000_0011), mk_ex(0,0,5'd6,32'h0000_AA7F,0)});

    foreach (tbl[k]) step(tbl[k].name, tbl[k].in, tbl[k].ex);

    // Stall holds A for three cycles while inputs change, then stall+flush bubbles.
    a_in = mk_in(1,1,0,0,0,0,0,5'd9,32'hDEAD_BEEF);
    a_ex = mk_ex(1,1,5'd9,32'hDEAD_BEEF,0);
    step("capture_a", a_in, a_ex);
    for (int k = 0; k < 3; k++) begin
      ri = rnd_in();
      ri.rst = 1'b0; ri.flush = 1'b0; ri.stall = 1'b1;
      step("stall_hold", ri, a_ex);
    end
    ri = rnd_in();
    ri.rst = 1'b0; ri.flush = 1'b1; ri.stall = 1'b1;
    step("stall_flush", ri, ZERO);

    // A misaligned flag held through a stall, then cleared by flush.
    step("mis_again", mk_in(1,1,1,0,1,0,1,5'd1,32'h0000_0013),
         mk_ex(1,!CHK,5'd1,32'hFFFF_8899,CHK));
    ri = mk_in(1,1,0,0,0,0,0,5'd2,32'h0);
    ri.stall = 1'b1;
    step("mis_stall", ri, mk_ex(1,!CHK,5'd1,32'hFFFF_8899,CHK));
    ri.stall = 1'b0; ri.flush = 1'b1;
    step("flush", ri, ZERO);
    step("post_flush", mk_in(1,1,0,0,0,0,0,5'd2,32'h0000_0042), mk_ex(1,1,5'd2,32'h0000_0042,0));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
